// File: rtl/tt_um_counter_param.sv
// Parameterised up/down modulo counter with prescaler, load, clear,
// wrap/saturate mode, a one-cycle wrap pulse and a sticky limit flag.
//
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   en        count enable (also gates the prescaler)
//   up        direction, 1 = increment, 0 = decrement
//   load      synchronous load of load_val (clamped to MODULO-1)
//   load_val  value to load
//   clear     synchronous clear (highest priority)
//   count     registered count value
//   wrap      registered one-cycle pulse on each wrap event
//   ovf       registered sticky limit-hit flag
//   at_max    count == MODULO-1
//   at_zero   count == 0
module tt_um_counter_param #(
    parameter int WIDTH    = 8,
    parameter int MODULO   = 256,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             ovf,
    output logic             at_max,
    output logic             at_zero
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);
    localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             pre_last;

    assign pre_last = (pre_q == PLAST);

    always_comb begin
        count_d = count_q;
        pre_d   = pre_q;
        ovf_d   = ovf_q;
        wrap_d  = 1'b0;
        if (clear) begin
            count_d = '0;
            pre_d   = '0;
            ovf_d   = 1'b0;
        end else if (load) begin
            // MAX < 2^WIDTH, so a same-width compare clamps correctly
            count_d = (load_val > MAX) ? MAX : load_val;
            pre_d   = '0;
            ovf_d   = 1'b0;
        end else if (en) begin
            pre_d = pre_last ? '0 : pre_q + PW'(1);
            if (pre_last) begin
                if (up) begin
                    if (count_q == MAX) begin
                        ovf_d = 1'b1;
                        if (SATURATE == 0) begin
                            count_d = '0;
                            wrap_d  = 1'b1;
                        end
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end else begin
                    if (count_q == '0) begin
                        ovf_d = 1'b1;
                        if (SATURATE == 0) begin
                            count_d = MAX;
                            wrap_d  = 1'b1;
                        end
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            pre_q   <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            pre_q   <= pre_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count   = count_q;
    assign wrap    = wrap_q;
    assign ovf     = ovf_q;
    assign at_max  = (count_q == MAX);
    assign at_zero = (count_q == '0);

endmodule
